spike_event_encoder: RTL and testbench
======================================

# spike_event_encoder

Serialises 16-bit neuron spike vectors into a stream of single-neuron address events for the next neuron core. Sits between one core's spike output and the next core's `event_addr`/`event_received` input. Buffers whole spike vectors in a small FIFO, then emits one event per set bit, lowest index first, under a valid/ready handshake so the downstream core can stall while it loads weights and accumulates.

## Interface
Parameters:
- N_NEURONS, 16: width of a spike vector.
- ADDR_W, 4: event address width; must equal log2(N_NEURONS).
- FIFO_DEPTH, 4: number of buffered spike vectors; power of two, at least 2.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- spike_in  in  N_NEURONS  spike vector from the upstream core; bit i set means neuron i fired.
- spike_valid  in  1  spike_in is valid this cycle.
- spike_ready  out  1  FIFO not full; a vector is accepted on a cycle where spike_valid and spike_ready are both high.
- event_addr  out  ADDR_W  neuron index of the current event.
- event_received  out  1  event valid; drives the downstream core's event input.
- event_ready  in  1  downstream core can accept an event this cycle. Only assert it when the core is idle and not entering its spike phase.
- busy  out  1  FIFO non-empty or an event mask is in flight.
- overflow  out  1  sticky; set when spike_valid is high with a non-zero vector while the FIFO is full.
- event_count  out  16  total events transferred; wraps 0xFFFF to 0x0000.

## Operation
- Input: when spike_valid is high with a non-zero spike_in and the FIFO is not full, the vector is written. All-zero vectors are always dropped and never set overflow. If the FIFO is full, the vector is dropped and overflow is set.
- Work register `mask` (N_NEURONS bits) holds the vector being serialised.
- FSM states: IDLE, FETCH, EMIT.
  - IDLE: event_received=0. If the FIFO is non-empty, go to FETCH.
  - FETCH: mask <= FIFO head, pop, go to EMIT. A popped vector is always non-zero.
  - EMIT: event_received=1; event_addr = index of the lowest set bit of mask.
- Transfer in EMIT: occurs when event_received && event_ready. On transfer:
  - that bit of mask is cleared;
  - event_count increments.
  - If the cleared mask is non-zero, stay in EMIT with the next lowest index.
  - Otherwise go to FETCH if the FIFO is non-empty, else IDLE. The FIFO is evaluated after this cycle's push.
- Stall: while in EMIT with event_ready low, event_addr and event_received hold steady.
- Idle address: event_addr = 0 whenever event_received = 0.
- Simultaneous push and pop in FETCH: both take effect and the occupancy count is unchanged. spike_ready is computed from the pre-pop count, so a push while full is dropped even during a pop.
- busy = (state != IDLE) || FIFO non-empty.
- Reset, asynchronous, including mid-operation:
  - FIFO emptied, mask cleared, state = IDLE;
  - outputs: event_received=0, event_addr=0, busy=0, overflow=0, event_count=0, spike_ready=1.
  - Any in-flight events are discarded.

## Timing
- Vector accepted at cycle 0 with the FSM in IDLE and the FIFO empty:
  - cycle 1: IDLE sees a non-empty FIFO;
  - cycle 2: FETCH;
  - cycle 3: first event_received high.
- With event_ready held high, a vector with k set bits produces events on k consecutive cycles.
- Back-to-back vectors: exactly one bubble cycle (FETCH) between the last event of one vector and the first event of the next.
- spike_ready and overflow are registered-state functions, valid from the cycle after reset deassertion.
- event_count updates on the clock edge that completes a transfer.

## Test plan
- Reset then push 0x8005, event_ready=1 -> events at cycles 3,4,5 with addr 0, 2, 15; event_count=3; busy low at cycle 6.
- Push 0x0003 with event_ready low for 5 cycles after EMIT is entered -> addr 0 held stable with event_received high for 5 cycles; after ready rises, addr 0 then addr 1 transfer on consecutive cycles.
- Push 5 vectors of 0xFFFF on consecutive cycles with event_ready=0 -> first 4 accepted, 5th dropped; spike_ready low when full; overflow=1 and stays 1.
- Push 0x0000 with spike_valid high -> no FIFO write, no events, overflow stays 0, busy stays 0.
- Push 0x0001 then 0x0002 on consecutive cycles, event_ready=1 -> addr 0, one bubble cycle with event_received=0, then addr 1.
- Assert reset mid-EMIT while serialising 0x00F0 -> event_received drops immediately; event_count=0, busy=0; after release no further events without a new push.

Source files
------------

// File: rtl/spike_event_encoder.sv
// spike_event_encoder
//   Buffers non-zero spike vectors in a small FIFO and serialises each one
//   into single-neuron address events, lowest index first, over a
//   valid/ready handshake towards the next neuron core.
//
// Ports:
//   clock          rising-edge clock
//   reset          asynchronous active-high reset
//   spike_in       spike vector from the upstream core (bit i = neuron i fired)
//   spike_valid    spike_in valid this cycle
//   spike_ready    FIFO not full
//   event_addr     neuron index of the current event (0 when no event)
//   event_received event valid towards the downstream core
//   event_ready    downstream core accepts an event this cycle
//   busy           FIFO non-empty or a mask is being serialised
//   overflow       sticky: non-zero vector offered while the FIFO was full
//   event_count    wrapping count of transferred events
module spike_event_encoder #(
  parameter int N_NEURONS  = 16,
  parameter int ADDR_W     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N_NEURONS-1:0] spike_in,
  input  logic                 spike_valid,
  output logic                 spike_ready,
  output logic [ADDR_W-1:0]    event_addr,
  output logic                 event_received,
  input  logic                 event_ready,
  output logic                 busy,
  output logic                 overflow,
  output logic [15:0]          event_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EMIT
  } state_t;

  state_t                state;
  logic [N_NEURONS-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W:0]        fifo_count;
  logic [PTR_W:0]        fifo_count_next;
  logic [N_NEURONS-1:0]  mask;
  logic [N_NEURONS-1:0]  mask_cleared;
  logic [ADDR_W-1:0]     low_idx;
  logic                  low_found;
  logic                  fifo_full;
  logic                  vec_nonzero;
  logic                  push;
  logic                  pop;
  logic                  transfer;

  assign fifo_full   = (fifo_count == (PTR_W+1)'(FIFO_DEPTH));
  assign vec_nonzero = |spike_in;
  // Fullness is taken from the registered count, so a push while full is
  // dropped even in a cycle where FETCH frees a slot.
  assign push        = spike_valid && vec_nonzero && !fifo_full;
  assign pop         = (state == FETCH);
  assign transfer    = (state == EMIT) && event_ready;

  always_comb begin
    fifo_count_next = fifo_count;
    case ({push, pop})
      2'b10:   fifo_count_next = fifo_count + (PTR_W+1)'(1);
      2'b01:   fifo_count_next = fifo_count - (PTR_W+1)'(1);
      default: fifo_count_next = fifo_count;
    endcase
  end

  // Priority encoder: index of the lowest set bit of the work mask.
  always_comb begin
    low_idx   = '0;
    low_found = 1'b0;
    for (int unsigned i = 0; i < N_NEURONS; i++) begin
      if (mask[i] && !low_found) begin
        low_idx   = ADDR_W'(i);
        low_found = 1'b1;
      end
    end
  end

  // Clearing the lowest set bit is the same as mask & (mask - 1).
  assign mask_cleared = mask & (mask - N_NEURONS'(1));

  assign spike_ready    = !fifo_full;
  assign event_received = (state == EMIT);
  assign event_addr     = (state == EMIT) ? low_idx : '0;
  assign busy           = (state != IDLE) || (fifo_count != '0);

  // Storage needs no reset; emptiness is tracked by the pointers and count.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr] <= spike_in;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      state       <= IDLE;
      mask        <= '0;
      overflow    <= 1'b0;
      event_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      fifo_count <= fifo_count_next;

      if (spike_valid && vec_nonzero && fifo_full) begin
        overflow <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (fifo_count != '0) begin
            state <= FETCH;
          end
        end
        FETCH: begin
          mask  <= fifo_mem[rd_ptr];
          state <= EMIT;
        end
        EMIT: begin
          if (transfer) begin
            mask        <= mask_cleared;
            event_count <= event_count + 16'd1;
            // Next vector is judged on occupancy including this cycle's push.
            if (mask_cleared != '0) begin
              state <= EMIT;
            end else if (fifo_count_next != '0) begin
              state <= FETCH;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spike_event_encoder.sv
// tb_spike_event_encoder
//   Scoreboard bench for spike_event_encoder: expected event addresses are
//   queued as vectors are driven and compared as transfers complete, with
//   cycle-accurate checks on handshake timing, stalls, overflow and reset.
module tb_spike_event_encoder;

  logic        clock;
  logic        reset;
  logic [15:0] spike_in;
  logic        spike_valid;
  logic        spike_ready;
  logic [3:0]  event_addr;
  logic        event_received;
  logic        event_ready;
  logic        busy;
  logic        overflow;
  logic [15:0] event_count;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [3:0]  exp_q [$];

  spike_event_encoder #(
    .N_NEURONS (16),
    .ADDR_W    (4),
    .FIFO_DEPTH(4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .spike_in      (spike_in),
    .spike_valid   (spike_valid),
    .spike_ready   (spike_ready),
    .event_addr    (event_addr),
    .event_received(event_received),
    .event_ready   (event_ready),
    .busy          (busy),
    .overflow      (overflow),
    .event_count   (event_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic neg();
    @(negedge clock);
  endtask

  // Queue the addresses an accepted vector must produce, lowest first.
  task automatic expect_vec(input logic [15:0] v);
    for (int i = 0; i < 16; i++) begin
      if (v[i]) exp_q.push_back(4'(i));
    end
  endtask

  // Transfer monitor: sampled on the falling edge, away from input changes.
  always @(negedge clock) begin
    if (!reset && event_received && event_ready) begin
      check("event_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        check("event_addr", 32'(event_addr), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    logic t1_er [7];
    reset       = 1'b1;
    spike_in    = '0;
    spike_valid = 1'b0;
    event_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    neg();
    check("rst_spike_ready", 32'(spike_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_event_received", 32'(event_received), 32'd0);
    check("rst_event_addr", 32'(event_addr), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_event_count", 32'(event_count), 32'd0);

    // 0x8005 with ready high: events at cycles 3,4,5, idle at cycle 6
    t1_er = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tick();
    spike_in = 16'h8005; spike_valid = 1'b1; event_ready = 1'b1;
    expect_vec(16'h8005);
    neg();
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) begin spike_valid = 1'b0; spike_in = '0; end
      neg();
      check("t1_event_received", 32'(event_received), 32'(t1_er[c]));
      if (c == 1) check("t1_busy_c1", 32'(busy), 32'd1);
    end
    check("t1_busy_c6", 32'(busy), 32'd0);
    check("t1_event_addr_idle", 32'(event_addr), 32'd0);
    check("t1_event_count", 32'(event_count), 32'd3);

    // All-zero vectors are dropped silently
    for (int c = 0; c < 3; c++) begin
      tick();
      spike_in = 16'h0000; spike_valid = 1'b1;
      neg();
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      spike_valid = 1'b0;
      neg();
      check("t4_event_received", 32'(event_received), 32'd0);
      check("t4_busy", 32'(busy), 32'd0);
      check("t4_overflow", 32'(overflow), 32'd0);
    end
    check("t4_spike_ready", 32'(spike_ready), 32'd1);
    check("t4_event_count", 32'(event_count), 32'd3);

    // 0x0003 stalled five cycles in EMIT, then released
    tick();
    spike_in = 16'h0003; spike_valid = 1'b1; event_ready = 1'b0;
    expect_vec(16'h0003);
    neg();
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 1) begin spike_valid = 1'b0; spike_in = '0; end
      if (c == 8) event_ready = 1'b1;
      neg();
      check("t2_event_received", 32'(event_received), 32'((c >= 3) && (c <= 9)));
      check("t2_event_addr", 32'(event_addr), 32'(c == 9));
    end
    check("t2_event_count", 32'(event_count), 32'd5);

    // Back-to-back vectors: one FETCH bubble between events
    tick();
    spike_in = 16'h0001; spike_valid = 1'b1; event_ready = 1'b1;
    expect_vec(16'h0001);
    neg();
    tick();
    spike_in = 16'h0002;
    expect_vec(16'h0002);
    neg();
    check("t5_event_received_c1", 32'(event_received), 32'd0);
    for (int c = 2; c <= 6; c++) begin
      tick();
      if (c == 2) begin spike_valid = 1'b0; spike_in = '0; end
      neg();
      check("t5_event_received", 32'(event_received), 32'((c == 3) || (c == 5)));
    end
    check("t5_event_count", 32'(event_count), 32'd7);

    // Fill the FIFO behind a stalled EMIT: 4 accepted, 5th dropped
    tick();
    spike_in = 16'h0001; spike_valid = 1'b1; event_ready = 1'b0;
    expect_vec(16'h0001);
    neg();
    for (int c = 1; c <= 3; c++) begin
      tick();
      spike_valid = 1'b0; spike_in = '0;
    end
    neg();
    check("t3_stalled", 32'(event_received), 32'd1);
    for (int k = 0; k < 5; k++) begin
      tick();
      spike_in = 16'hFFFF; spike_valid = 1'b1;
      if (k < 4) expect_vec(16'hFFFF);
      neg();
      check("t3_spike_ready", 32'(spike_ready), 32'(k < 4));
      check("t3_overflow_pre", 32'(overflow), 32'd0);
    end
    tick();
    spike_valid = 1'b0; spike_in = '0;
    neg();
    check("t3_overflow_set", 32'(overflow), 32'd1);
    check("t3_full", 32'(spike_ready), 32'd0);
    tick();
    event_ready = 1'b1;
    for (int c = 0; c < 300; c++) begin
      neg();
      if (!busy) break;
      tick();
    end
    check("t3_drain_timeout", 32'(busy), 32'd0);
    check("t3_overflow_sticky", 32'(overflow), 32'd1);
    check("t3_sb_drained", 32'(exp_q.size()), 32'd0);
    check("t3_event_count", 32'(event_count), 32'd72);

    // Reset while serialising 0x00F0
    tick();
    spike_in = 16'h00F0; spike_valid = 1'b1; event_ready = 1'b1;
    expect_vec(16'h00F0);
    neg();
    for (int c = 1; c <= 3; c++) begin
      tick();
      spike_valid = 1'b0; spike_in = '0;
    end
    neg();
    check("t6_emitting", 32'(event_received), 32'd1);
    tick();
    reset = 1'b1;
    #1;
    exp_q.delete();
    check("t6_event_received", 32'(event_received), 32'd0);
    check("t6_event_addr", 32'(event_addr), 32'd0);
    check("t6_event_count", 32'(event_count), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_overflow", 32'(overflow), 32'd0);
    check("t6_spike_ready", 32'(spike_ready), 32'd1);
    tick();
    tick();
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      neg();
      check("t6_post_event_received", 32'(event_received), 32'd0);
      check("t6_post_busy", 32'(busy), 32'd0);
      tick();
    end
    check("t6_post_event_count", 32'(event_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
